// File: rtl/instr_encoder.sv
// RV32I instruction encoder with LI pseudo expansion.
// Two-entry output holding stage with valid/ready handshakes.
module instr_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_kind,
    input  logic [2:0]       in_funct3,
    input  logic             in_f7b5,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_last,
    output logic             err,
    output logic [CNT_W-1:0] word_count
);

    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FIRST = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      pend_q, pend_d;
    logic             last_q, last_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [31:0] enc_w0, enc_w1;
    logic        enc_two, enc_ill;
    logic        li_small;
    logic [19:0] li_hi;
    logic        accept, consume, load_new;

    // (imm + 0x800) >> 12 is imm[31:12] plus the carry out of imm[11]
    assign li_small = (in_imm[31:11] == {21{in_imm[11]}});
    assign li_hi    = in_imm[31:12] + {19'd0, in_imm[11]};

    always_comb begin
        enc_w0  = '0;
        enc_w1  = '0;
        enc_two = 1'b0;
        enc_ill = 1'b0;
        unique case (in_kind)
            4'd0: enc_w0 = {1'b0, in_f7b5, 5'd0, in_rs2, in_rs1,
                            in_funct3, in_rd, OPC_OP};
            4'd1: begin
                if (in_funct3 == 3'b001 || in_funct3 == 3'b101)
                    enc_w0 = {1'b0, in_f7b5, 5'd0, in_imm[4:0], in_rs1,
                              in_funct3, in_rd, OPC_OP_IMM};
                else
                    enc_w0 = {in_imm[11:0], in_rs1, in_funct3,
                              in_rd, OPC_OP_IMM};
            end
            4'd2: enc_w0 = {in_imm[11:0], in_rs1, in_funct3,
                            in_rd, OPC_LOAD};
            4'd3: enc_w0 = {in_imm[11:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:0], OPC_STORE};
            4'd4: enc_w0 = {in_imm[12], in_imm[10:5], in_rs2, in_rs1,
                            in_funct3, in_imm[4:1], in_imm[11], OPC_BRANCH};
            4'd5: enc_w0 = {in_imm[20], in_imm[10:1], in_imm[11],
                            in_imm[19:12], in_rd, OPC_JAL};
            4'd6: enc_w0 = {in_imm[11:0], in_rs1, 3'b000,
                            in_rd, OPC_JALR};
            4'd7: enc_w0 = {in_imm[31:12], in_rd, OPC_LUI};
            4'd8: enc_w0 = {in_imm[31:12], in_rd, OPC_AUIPC};
            4'd9: begin
                if (li_small) begin
                    enc_w0 = {in_imm[11:0], 5'd0, 3'b000,
                              in_rd, OPC_OP_IMM};
                end else begin
                    enc_w0  = {li_hi, in_rd, OPC_LUI};
                    enc_w1  = {in_imm[11:0], in_rd, 3'b000,
                               in_rd, OPC_OP_IMM};
                    enc_two = (in_imm[11:0] != 12'd0);
                end
            end
            default: enc_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
            instr_q <= '0;
            pend_q  <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            pend_q  <= pend_d;
            last_q  <= last_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_EMPTY: begin
                if (load_new)
                    state_d = enc_two ? S_FIRST : S_ONE;
            end
            S_ONE: begin
                if (consume) begin
                    if (load_new)
                        state_d = enc_two ? S_FIRST : S_ONE;
                    else
                        state_d = S_EMPTY;
                end
            end
            S_FIRST: begin
                if (consume)
                    state_d = S_ONE;
            end
            default: state_d = S_EMPTY;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_EMPTY) ||
                    (state_q == S_ONE && out_ready);
        out_valid = (state_q != S_EMPTY);
        accept    = in_valid && in_ready;
        consume   = out_valid && out_ready;
        load_new  = accept && !enc_ill;

        instr_d = instr_q;
        pend_d  = pend_q;
        last_d  = last_q;
        err_d   = accept && enc_ill;
        cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, consume};

        if (state_q == S_FIRST && consume) begin
            instr_d = pend_q;
            last_d  = 1'b1;
        end else if (load_new) begin
            instr_d = enc_w0;
            pend_d  = enc_w1;
            last_d  = !enc_two;
        end
    end

    assign out_instr  = instr_q;
    assign out_last   = last_q;
    assign err        = err_q;
    assign word_count = cnt_q;

endmodule
